// File: rtl/pc_control_unit_pkg.sv
// Shared PC-select and control-FSM encodings.
// Fetch uses these as well, so the encodings must stay in step with it.
package pc_control_unit_pkg;

    localparam int XLEN  = 32;
    localparam int REG_W = 5;

    typedef enum logic [3:0] {
        PC_SEL_SEQ    = 4'b0000,
        PC_SEL_BRANCH = 4'b0001,
        PC_SEL_JUMP   = 4'b0010
    } pc_sel_t;

    typedef enum logic {
        RUN      = 1'b0,
        MEM_WAIT = 1'b1
    } pc_state_t;

endpackage

// File: rtl/pc_control_unit_hazard_detect.sv
// Load-use compare between the EX load and the ID source registers.
// x0 is never a real dependency.
module hazard_detect
    import pc_control_unit_pkg::*;
(
    input  logic [REG_W-1:0] id_rs1,
    input  logic [REG_W-1:0] id_rs2,
    input  logic [REG_W-1:0] ex_rd,
    input  logic             ex_mem_read,
    output logic             load_use
);

    assign load_use = ex_mem_read
                   && (ex_rd != '0)
                   && ((ex_rd == id_rs1) || (ex_rd == id_rs2));

endmodule

// File: rtl/pc_control_unit.sv
// PC redirect / stall controller: branch > jump > load-use > sequential,
// with redirects held pending across instruction-memory wait cycles.
module pc_control_unit
    import pc_control_unit_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             ex_branch_taken,
    input  logic [XLEN-1:0]  ex_branch_target,
    input  logic             id_jump,
    input  logic [XLEN-1:0]  id_jump_target,
    input  logic [REG_W-1:0] id_rs1,
    input  logic [REG_W-1:0] id_rs2,
    input  logic [REG_W-1:0] ex_rd,
    input  logic             ex_mem_read,
    input  logic             imem_ready,
    output logic             stall_out,
    output logic [3:0]       pc_src_sel_out,
    output logic [XLEN-1:0]  branch_target_out,
    output logic [XLEN-1:0]  jump_target_out,
    output logic             if_id_stall,
    output logic             if_id_flush,
    output logic             id_ex_flush,
    output logic [31:0]      stall_count
);

    pc_state_t       state;
    logic            pend_valid;
    pc_sel_t         pend_sel;
    logic [XLEN-1:0] pend_target;
    logic            lu_seen;
    logic            lu_next;
    logic            load_use;
    pc_sel_t         sel;

    hazard_detect u_hazard_detect (
        .id_rs1      (id_rs1),
        .id_rs2      (id_rs2),
        .ex_rd       (ex_rd),
        .ex_mem_read (ex_mem_read),
        .load_use    (load_use)
    );

    assign pc_src_sel_out = sel;

    always_comb begin
        stall_out         = 1'b0;
        sel               = PC_SEL_SEQ;
        branch_target_out = '0;
        jump_target_out   = '0;
        if_id_stall       = 1'b0;
        if_id_flush       = 1'b0;
        id_ex_flush       = 1'b0;
        lu_next           = lu_seen;
        if (!reset) begin
            lu_next = 1'b0;
        end else if (!imem_ready) begin
            stall_out   = 1'b1;
            if_id_stall = 1'b1;
        end else if (ex_branch_taken) begin
            sel               = PC_SEL_BRANCH;
            branch_target_out = ex_branch_target;
            if_id_flush       = 1'b1;
            id_ex_flush       = 1'b1;
            lu_next           = 1'b0;
        end else if (pend_valid) begin
            sel         = pend_sel;
            if_id_flush = 1'b1;
            lu_next     = 1'b0;
            if (pend_sel == PC_SEL_BRANCH) begin
                branch_target_out = pend_target;
                id_ex_flush       = 1'b1;
            end else begin
                jump_target_out = pend_target;
            end
        end else if (id_jump) begin
            sel             = PC_SEL_JUMP;
            jump_target_out = id_jump_target;
            if_id_flush     = 1'b1;
            lu_next         = 1'b0;
        end else begin
            // A held hazard stalls once; lu_seen re-arms when it drops.
            if (load_use && !lu_seen) begin
                stall_out   = 1'b1;
                if_id_stall = 1'b1;
                id_ex_flush = 1'b1;
            end
            lu_next = load_use;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state       <= RUN;
            pend_valid  <= 1'b0;
            pend_sel    <= PC_SEL_SEQ;
            pend_target <= '0;
            lu_seen     <= 1'b0;
            stall_count <= '0;
        end else begin
            lu_seen <= lu_next;
            if (stall_out && (stall_count != 32'hFFFF_FFFF)) begin
                stall_count <= stall_count + 32'd1;
            end
            if (!imem_ready) begin
                state <= MEM_WAIT;
                // A pending branch is never displaced by a younger jump.
                if (ex_branch_taken) begin
                    pend_valid  <= 1'b1;
                    pend_sel    <= PC_SEL_BRANCH;
                    pend_target <= ex_branch_target;
                end else if (id_jump &&
                             !(pend_valid && pend_sel == PC_SEL_BRANCH)) begin
                    pend_valid  <= 1'b1;
                    pend_sel    <= PC_SEL_JUMP;
                    pend_target <= id_jump_target;
                end
            end else begin
                state      <= RUN;
                pend_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_pc_control_unit.sv
// Bench for pc_control_unit: vector table plus wait/reset sequences.
// Expected records go through a scoreboard queue.
module tb_pc_control_unit;

    typedef struct {
        logic        rst;
        logic        rdy;
        logic        br;
        logic [31:0] bt;
        logic        jp;
        logic [31:0] jt;
        logic        mr;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic        e_stall;
        logic [3:0]  e_sel;
        logic [31:0] e_bt;
        logic [31:0] e_jt;
        logic        e_ifs;
        logic        e_iff;
        logic        e_ief;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        ex_branch_taken;
    logic [31:0] ex_branch_target;
    logic        id_jump;
    logic [31:0] id_jump_target;
    logic [4:0]  id_rs1, id_rs2, ex_rd;
    logic        ex_mem_read;
    logic        imem_ready;
    logic        stall_out;
    logic [3:0]  pc_src_sel_out;
    logic [31:0] branch_target_out, jump_target_out;
    logic        if_id_stall, if_id_flush, id_ex_flush;
    logic [31:0] stall_count;

    int   tests  = 0;
    int   fails  = 0;
    int   vidx   = 0;
    logic [31:0] exp_cnt = 0;
    logic        cnt_known = 1'b0;
    vec_t sb[$];
    vec_t tbl[$];

    always #5 clk = ~clk;

    pc_control_unit dut (
        .clk               (clk),
        .reset             (reset),
        .ex_branch_taken   (ex_branch_taken),
        .ex_branch_target  (ex_branch_target),
        .id_jump           (id_jump),
        .id_jump_target    (id_jump_target),
        .id_rs1            (id_rs1),
        .id_rs2            (id_rs2),
        .ex_rd             (ex_rd),
        .ex_mem_read       (ex_mem_read),
        .imem_ready        (imem_ready),
        .stall_out         (stall_out),
        .pc_src_sel_out    (pc_src_sel_out),
        .branch_target_out (branch_target_out),
        .jump_target_out   (jump_target_out),
        .if_id_stall       (if_id_stall),
        .if_id_flush       (if_id_flush),
        .id_ex_flush       (id_ex_flush),
        .stall_count       (stall_count)
    );

    function automatic vec_t mk(
        input logic rst, input logic rdy,
        input logic br, input logic [31:0] bt,
        input logic jp, input logic [31:0] jt,
        input logic mr, input logic [4:0] rd,
        input logic [4:0] rs1, input logic [4:0] rs2,
        input logic es, input logic [3:0] esel,
        input logic [31:0] ebt, input logic [31:0] ejt,
        input logic eifs, input logic eiff, input logic eief);
        vec_t v;
        v.rst = rst; v.rdy = rdy; v.br = br; v.bt = bt;
        v.jp = jp; v.jt = jt; v.mr = mr; v.rd = rd;
        v.rs1 = rs1; v.rs2 = rs2; v.e_stall = es; v.e_sel = esel;
        v.e_bt = ebt; v.e_jt = ejt; v.e_ifs = eifs;
        v.e_iff = eiff; v.e_ief = eief;
        return v;
    endfunction

    task automatic cmp(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL v%0d %s: got %h expected %h", vidx, nm, act, exp);
        end
    endtask

    task automatic apply(input vec_t v);
        vec_t e;
        @(negedge clk);
        reset            = v.rst;
        imem_ready       = v.rdy;
        ex_branch_taken  = v.br;
        ex_branch_target = v.bt;
        id_jump          = v.jp;
        id_jump_target   = v.jt;
        ex_mem_read      = v.mr;
        ex_rd            = v.rd;
        id_rs1           = v.rs1;
        id_rs2           = v.rs2;
        sb.push_back(v);
        #2;
        e = sb.pop_front();
        cmp("stall_out", {31'b0, stall_out}, {31'b0, e.e_stall});
        cmp("pc_src_sel", {28'b0, pc_src_sel_out}, {28'b0, e.e_sel});
        cmp("branch_target", branch_target_out, e.e_bt);
        cmp("jump_target", jump_target_out, e.e_jt);
        cmp("if_id_stall", {31'b0, if_id_stall}, {31'b0, e.e_ifs});
        cmp("if_id_flush", {31'b0, if_id_flush}, {31'b0, e.e_iff});
        cmp("id_ex_flush", {31'b0, id_ex_flush}, {31'b0, e.e_ief});
        if (e.rst && cnt_known) cmp("stall_count", stall_count, exp_cnt);
        if (!e.rst) begin
            exp_cnt   = 0;
            cnt_known = 1'b1;
        end else if (e.e_stall && exp_cnt != 32'hFFFF_FFFF) begin
            exp_cnt = exp_cnt + 1;
        end
        vidx++;
    endtask

    localparam logic [3:0] SQ = 4'b0000;
    localparam logic [3:0] BR = 4'b0001;
    localparam logic [3:0] JP = 4'b0010;

    initial begin
        reset = 1'b0; imem_ready = 1'b1;
        ex_branch_taken = 1'b0; ex_branch_target = '0;
        id_jump = 1'b0; id_jump_target = '0;
        ex_mem_read = 1'b0; ex_rd = '0; id_rs1 = '0; id_rs2 = '0;

        // rst rdy br bt jp jt mr rd rs1 rs2 | stall sel bt jt ifs iff ief
        tbl.push_back(mk(0,0,1,32'h40,1,32'h50,1,5,5,2, 0,SQ,0,0,0,0,0));
        tbl.push_back(mk(0,1,0,0,0,0,0,0,1,2, 0,SQ,0,0,0,0,0));
        tbl.push_back(mk(1,1,0,0,0,0,0,0,1,2, 0,SQ,0,0,0,0,0));
        tbl.push_back(mk(1,1,0,0,0,0,1,5,1,5, 1,SQ,0,0,1,0,1));
        tbl.push_back(mk(1,1,0,0,0,0,1,5,1,5, 0,SQ,0,0,0,0,0));
        tbl.push_back(mk(1,1,0,0,0,0,1,0,0,0, 0,SQ,0,0,0,0,0));
        tbl.push_back(mk(1,1,0,0,0,0,1,7,7,2, 1,SQ,0,0,1,0,1));
        tbl.push_back(mk(1,1,0,0,0,0,0,0,1,2, 0,SQ,0,0,0,0,0));
        tbl.push_back(mk(1,1,1,32'h40,1,32'h50,1,3,3,2,
                         0,BR,32'h40,0,0,1,1));
        tbl.push_back(mk(1,1,0,0,1,32'h50,1,3,3,2,
                         0,JP,0,32'h50,0,1,0));
        tbl.push_back(mk(1,1,0,0,0,0,1,3,3,2, 1,SQ,0,0,1,0,1));
        tbl.push_back(mk(1,1,0,0,0,0,0,0,1,2, 0,SQ,0,0,0,0,0));
        for (int i = 0; i < tbl.size(); i++) apply(tbl[i]);

        // jump held across three wait cycles
        for (int i = 0; i < 3; i++)
            apply(mk(1,0,0,0,1,32'h50,0,0,1,2, 1,SQ,0,0,1,0,0));
        apply(mk(1,1,0,0,1,32'h50,0,0,1,2, 0,JP,0,32'h50,0,1,0));
        apply(mk(1,1,0,0,0,0,0,0,1,2, 0,SQ,0,0,0,0,0));

        // pending jump overwritten by branch, later jump ignored
        apply(mk(1,0,0,0,1,32'h50,0,0,1,2, 1,SQ,0,0,1,0,0));
        apply(mk(1,0,1,32'h80,0,0,0,0,1,2, 1,SQ,0,0,1,0,0));
        apply(mk(1,0,0,0,1,32'h60,0,0,1,2, 1,SQ,0,0,1,0,0));
        apply(mk(1,1,0,0,0,0,0,0,1,2, 0,BR,32'h80,0,0,1,1));
        apply(mk(1,1,0,0,0,0,0,0,1,2, 0,SQ,0,0,0,0,0));

        // live branch on the ready cycle beats pending jump
        apply(mk(1,0,0,0,1,32'h50,0,0,1,2, 1,SQ,0,0,1,0,0));
        apply(mk(1,1,1,32'h90,0,0,0,0,1,2, 0,BR,32'h90,0,0,1,1));
        apply(mk(1,1,0,0,0,0,0,0,1,2, 0,SQ,0,0,0,0,0));

        // reset mid-wait discards pending jump and clears count
        apply(mk(1,0,0,0,1,32'h50,0,0,1,2, 1,SQ,0,0,1,0,0));
        apply(mk(1,0,0,0,0,0,0,0,1,2, 1,SQ,0,0,1,0,0));
        apply(mk(0,0,0,0,1,32'h50,0,0,1,2, 0,SQ,0,0,0,0,0));
        apply(mk(1,1,0,0,0,0,0,0,1,2, 0,SQ,0,0,0,0,0));
        apply(mk(1,1,0,0,0,0,0,0,1,2, 0,SQ,0,0,0,0,0));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/pc_control_unit.md
PC_CONTROL_UNIT -- requirements
Module: pc_control_unit

Interface
REQ-001 SHALL have ports: clk  in  1  system clock, all state updates on rising edge.
REQ-002 SHALL have ports: reset  in  1  synchronous, active-low reset (0 = reset, sampled on rising clk).
REQ-003 SHALL have ports: ex_branch_taken  in  1  branch in EX resolved taken.
REQ-004 SHALL have ports: ex_branch_target  in  32  branch target from EX.
REQ-005 SHALL have ports: id_jump  in  1  JAL/JALR decoded in ID.
REQ-006 SHALL have ports: id_jump_target  in  32  jump target from ID.
REQ-007 SHALL have ports: id_rs1, id_rs2  in  5 each  source registers of the ID instruction.
REQ-008 SHALL have ports: ex_rd  in  5, ex_mem_read  in  1  destination register and load flag of the EX instruction.
REQ-009 SHALL have ports: imem_ready  in  1  instruction memory returned valid data this cycle.
REQ-010 SHALL have ports: stall_out  out  1  drives fetch stall_in (hold PC).
REQ-011 SHALL have ports: pc_src_sel_out  out  4  drives fetch pc_src_sel_in: 4'b0000 PC+4, 4'b0001 branch, 4'b0010 jump.
REQ-012 SHALL have ports: branch_target_out, jump_target_out  out  32 each  drive fetch target inputs.
REQ-013 SHALL have ports: if_id_stall, if_id_flush, id_ex_flush  out  1 each  pipeline-register controls.
REQ-014 SHALL have ports: stall_count  out  32  cycles with stall_out=1 since reset.

Function
REQ-015 SHALL implement states RUN and MEM_WAIT; RUN->MEM_WAIT when imem_ready=0; MEM_WAIT->RUN on the first cycle imem_ready=1.
REQ-016 SHALL detect load-use when ex_mem_read=1, ex_rd!=0 and ex_rd equals id_rs1 or id_rs2.
REQ-017 SHALL, in RUN, prioritise: branch > jump > load-use > sequential.
REQ-018 SHALL, on branch: pc_src_sel_out=0001, branch_target_out=ex_branch_target, if_id_flush=1, id_ex_flush=1, stall_out=0, same cycle (combinational).
REQ-019 SHALL, on jump without branch: pc_src_sel_out=0010, jump_target_out=id_jump_target, if_id_flush=1, id_ex_flush=0.
REQ-020 SHALL, on load-use without redirect: stall_out=1, if_id_stall=1, id_ex_flush=1 for exactly one cycle per hazard occurrence.
REQ-021 SHALL, in MEM_WAIT, hold stall_out=1, if_id_stall=1, pc_src_sel_out=0000, all flushes 0.
REQ-022 SHALL latch a branch or jump arriving in MEM_WAIT or in the RUN cycle with imem_ready=0 into a pending register (valid, sel, target); a later branch overwrites a pending jump, never the reverse.
REQ-023 SHALL apply a pending redirect in the cycle imem_ready returns (flush as REQ-018/019), then clear pending valid; new live branch in that cycle overrides pending.
REQ-024 SHALL, with no event, drive pc_src_sel_out=0000, targets 0, all control outputs 0.
REQ-025 SHALL increment stall_count each cycle stall_out=1, saturating at 32'hFFFF_FFFF.

Reset
REQ-026 SHALL on reset=0 at rising edge: state RUN, pending cleared, stall_count=0.
REQ-027 SHALL force stall_out=0, pc_src_sel_out=0000, targets 0, all flushes/stalls 0 while reset=0, regardless of inputs.
REQ-028 SHALL discard any pending redirect when reset asserts mid-MEM_WAIT.

Structure
REQ-029 SHALL place pc_src_sel encodings (PC_SEL_SEQ, PC_SEL_BRANCH, PC_SEL_JUMP) and state encodings in a shared package used also by fetch.
REQ-030 SHALL contain one sub-module, hazard_detect (combinational load-use compare per REQ-016).

Verification
REQ-031 SHALL test: ex_mem_read=1, ex_rd=5, id_rs2=5 -> one cycle stall_out=1, id_ex_flush=1, stall_count=1; ex_rd=0 -> no stall.
REQ-032 SHALL test: ex_branch_taken=1 target 0x40 and id_jump=1 target 0x50 same cycle -> sel 0001, branch_target_out 0x40, both flushes 1.
REQ-033 SHALL test: id_jump=1 target 0x50 with imem_ready=0 for 3 cycles -> stall_out=1 three cycles, then sel 0010, target 0x50, if_id_flush=1 on ready cycle.
REQ-034 SHALL test: pending jump 0x50 then branch 0x80 during MEM_WAIT -> branch 0x80 applied on ready.
REQ-035 SHALL test: reset=0 during MEM_WAIT with pending jump -> after reset release, sel 0000, no redirect, stall_count=0.
